// File: rtl/operand_arb_mux.sv
// rtl/operand_arb_mux.sv - N-channel operand selector with fixed/round-robin arbitration and a registered output stage
module operand_arb_mux #(
    parameter  int WIDTH  = 16,
    parameter  int NUM_CH = 4,
    localparam int SEL_W  = $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    input  logic [NUM_CH-1:0]       in_valid,
    output logic [NUM_CH-1:0]       in_ready,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_ch,
    output logic                    out_valid,
    input  logic                    out_ready
);

    localparam int NPAD = 1 << SEL_W;

    logic             free;
    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] grant;
    logic             gvalid;
    logic [SEL_W-1:0] rr_grant;
    logic [NPAD-1:0]  valid_pad;
    logic [SEL_W-1:0] ptr_next;

    assign free      = !out_valid || out_ready;
    // Padding lets sel index safely when NUM_CH is not a power of two.
    assign valid_pad = NPAD'(in_valid);

    // Walk the scan order backwards so the earliest requester wins the last write.
    always_comb begin
        int idx;
        rr_grant = '0;
        idx      = 0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            if (in_valid[idx]) begin
                rr_grant = SEL_W'(idx);
            end
        end
    end

    always_comb begin
        grant  = '0;
        gvalid = 1'b0;
        if (mode) begin
            grant  = rr_grant;
            gvalid = |in_valid;
        end else if (int'(sel) < NUM_CH && valid_pad[sel]) begin
            grant  = sel;
            gvalid = 1'b1;
        end
    end

    always_comb begin
        in_ready = '0;
        if (rst_n && free && gvalid) begin
            in_ready = NUM_CH'(1) << grant;
        end
    end

    assign ptr_next = (int'(grant) == NUM_CH - 1) ? '0 : grant + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr       <= '0;
        end else if (free) begin
            if (gvalid) begin
                out_valid <= 1'b1;
                out_data  <= in_data[grant*WIDTH +: WIDTH];
                out_ch    <= grant;
                ptr       <= ptr_next;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_operand_arb_mux.sv
// tb/tb_operand_arb_mux.sv - scoreboard bench for operand_arb_mux
module tb_operand_arb_mux;

    logic        clk;
    logic        rst_n;
    logic [63:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic        mode;
    logic [1:0]  sel;
    logic [15:0] out_data;
    logic [1:0]  out_ch;
    logic        out_valid;
    logic        out_ready;

    logic [15:0] chdata [4];
    logic [17:0] exp_q [$];
    int          total;
    int          passed;

    operand_arb_mux #(.WIDTH(16), .NUM_CH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            in_data[i*16 +: 16] = chdata[i];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: drive inputs, check handshake mid-cycle, predict the transfer.
    task automatic step(input logic [3:0] v, input logic m, input logic [1:0] s,
                        input logic ordy, input logic [3:0] exp_rdy, input int exp_ov);
        in_valid  = v;
        mode      = m;
        sel       = s;
        out_ready = ordy;
        @(negedge clk);
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        if (exp_ov >= 0) begin
            chk("out_valid", 32'(out_valid), 32'(exp_ov));
        end
        for (int i = 0; i < 4; i++) begin
            if (exp_rdy[i]) begin
                exp_q.push_back({2'(i), chdata[i]});
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted output word is compared with the oldest prediction.
    initial begin
        logic [17:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 32'(out_ch), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_ch", 32'(out_ch), 32'(e[17:16]));
                    chk("out_data", 32'(out_data), 32'(e[15:0]));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        total     = 0;
        passed    = 0;
        rst_n     = 1'b0;
        in_valid  = 4'b1111;
        mode      = 1'b1;
        sel       = 2'd0;
        out_ready = 1'b1;
        chdata[0] = 16'hBEEF;
        chdata[1] = 16'h2222;
        chdata[2] = 16'h3333;
        chdata[3] = 16'h4444;

        // Reset state, with requests present: nothing granted
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Load BEEF, then stall it
        step(4'b0001, 1'b0, 2'd0, 1'b0, 4'b0001, 0);
        step(4'b0000, 1'b0, 2'd0, 1'b0, 4'b0000, 1);
        chk("stall_data", 32'(out_data), 32'hBEEF);

        // Asynchronous reset between edges
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("async_out_valid", 32'(out_valid), 32'd0);
        chk("async_out_data", 32'(out_data), 32'd0);
        chk("async_out_ch", 32'(out_ch), 32'd0);
        in_valid = 4'b1111;
        #1;
        chk("async_in_ready", 32'(in_ready), 32'd0);
        chdata[0] = 16'h1111;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Round-robin fairness from reset, first grant ch0
        step(4'b1111, 1'b1, 2'd0, 1'b1, 4'b0001, 0);
        step(4'b1111, 1'b1, 2'd0, 1'b1, 4'b0010, 1);
        step(4'b1111, 1'b1, 2'd0, 1'b1, 4'b0100, 1);
        step(4'b1111, 1'b1, 2'd0, 1'b1, 4'b1000, 1);
        step(4'b1111, 1'b1, 2'd0, 1'b1, 4'b0001, 1);
        step(4'b1111, 1'b1, 2'd0, 1'b1, 4'b0010, 1);
        step(4'b1111, 1'b1, 2'd0, 1'b1, 4'b0100, 1);
        step(4'b1111, 1'b1, 2'd0, 1'b1, 4'b1000, 1);

        // Fixed mode sel=2, sustained
        step(4'b1111, 1'b0, 2'd2, 1'b1, 4'b0100, 1);
        step(4'b1111, 1'b0, 2'd2, 1'b1, 4'b0100, 1);
        step(4'b1111, 1'b0, 2'd2, 1'b1, 4'b0100, 1);

        // Fixed mode with absent request on sel=1
        step(4'b1101, 1'b0, 2'd1, 1'b1, 4'b0000, 1);
        step(4'b1101, 1'b0, 2'd1, 1'b1, 4'b0000, 0);
        chk("idle_hold_data", 32'(out_data), 32'h3333);
        chk("idle_hold_ch", 32'(out_ch), 32'd2);

        // Fixed grant on ch3 wraps ptr to 0, then sparse round-robin
        step(4'b1000, 1'b0, 2'd3, 1'b1, 4'b1000, 0);
        step(4'b1010, 1'b1, 2'd0, 1'b1, 4'b0010, 1);
        step(4'b1010, 1'b1, 2'd0, 1'b1, 4'b1000, 1);
        step(4'b1010, 1'b1, 2'd0, 1'b1, 4'b0010, 1);
        step(4'b1010, 1'b1, 2'd0, 1'b1, 4'b1000, 1);

        // Backpressure for 3 cycles holding ch3
        for (int i = 0; i < 3; i++) begin
            step(4'b1111, 1'b1, 2'd0, 1'b0, 4'b0000, 1);
            chk("bp_data", 32'(out_data), 32'h4444);
            chk("bp_ch", 32'(out_ch), 32'd3);
        end
        // Release: ptr is 0 after the ch3 wrap, so ch0 is next, no bubble
        step(4'b1111, 1'b1, 2'd0, 1'b1, 4'b0001, 1);
        step(4'b0000, 1'b1, 2'd0, 1'b1, 4'b0000, 1);
        step(4'b0000, 1'b1, 2'd0, 1'b1, 4'b0000, 0);

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/operand_arb_mux.md
# operand_arb_mux

Parametrised N-channel, WIDTH-bit operand selector with valid/ready handshaking and one registered output stage. It replaces the purely combinational 4:1 16-bit operand multiplexer in the ALU datapath. Upstream operand sources can now stall, and the block arbitrates among them either by explicit select or by round-robin. It sits between the operand producers (register read ports, immediate unit, forwarding paths) and the ALU input register.

## Interface
- WIDTH, 16, data width of each channel and of the output.
- NUM_CH, 4, number of input channels (2..16).
- SEL_W, derived localparam = $clog2(NUM_CH), width of the channel index.

- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous and active-low.
- in_data  input  NUM_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  NUM_CH  per-channel request.
- in_ready  output  NUM_CH  per-channel accept; one-hot or zero.
- mode  input  1  0 = fixed select, 1 = round-robin.
- sel  input  SEL_W  channel index used in fixed mode.
- out_data  output  WIDTH  registered selected operand.
- out_ch  output  SEL_W  index of the channel that produced out_data.
- out_valid  output  1  output register holds data.
- out_ready  input  1  downstream accept.

## Operation
- `free = !out_valid || out_ready`.
- Fixed mode (mode=0):
  - If `sel < NUM_CH` and `in_valid[sel]`, then `grant = sel` and `gvalid = 1`.
  - Otherwise `gvalid = 0`. When `sel >= NUM_CH`, no grant is ever made.
- Round-robin mode (mode=1):
  - Scan channels `ptr, ptr+1, …, NUM_CH-1, 0, …, ptr-1`.
  - The first channel with `in_valid` set is the grant. `gvalid = |in_valid`.
- `in_ready[i] = free && gvalid && (grant == i)`. in_ready never depends on out_valid alone, and never asserts for a non-requesting channel.
- Transfer from channel i occurs when `in_valid[i] && in_ready[i]`. On transfer:
  - `out_data <= in_data[grant]`, `out_ch <= grant`, `out_valid <= 1`.
  - `ptr <= (grant == NUM_CH-1) ? 0 : grant+1`. ptr updates in both modes, so switching to round-robin continues fairly from the last grant.
- If `free` is set and `gvalid` is clear: `out_valid <= 0`. out_data and out_ch hold their last values.
- If `out_valid && !out_ready`: out_data, out_ch and out_valid hold. All in_ready are 0.
- mode and sel are sampled combinationally every cycle. A change takes effect in the same cycle's grant. A change never corrupts a held output.
- Reset (asynchronous, any cycle, including mid-stall) forces:
  - `out_valid = 0`, `out_data = 0`, `out_ch = 0`, `ptr = 0`.
  - in_ready goes to 0 while `rst_n = 0`.

## Timing
- Latency: one cycle from the accepted input edge to out_valid/out_data.
- Throughput: one transfer per cycle while out_ready is held high.
- No combinational path from in_data to out_data. in_ready depends combinationally on in_valid, mode, sel, out_valid and out_ready.
- Round-robin fairness: with all NUM_CH channels continuously valid and out_ready=1, each channel is granted exactly once every NUM_CH cycles.
- Wrap-around: a grant of channel NUM_CH-1 sets ptr to 0.
- Simultaneous drain and refill: `out_valid=1`, `out_ready=1` and a valid grant in the same cycle gives back-to-back output with no bubble.
- Reset release: the first grant can occur in the first clock edge after rst_n rises. With all channels valid in round-robin mode, that grant is channel 0.

## Test plan
- Reset mid-stall: load 16'hBEEF, hold out_ready=0, assert rst_n=0 asynchronously between edges -> out_valid, out_data and out_ch go to 0 immediately; after release, round-robin with all valid grants ch0 first.
- Fixed mode: mode=0, sel=2, in_valid=4'b1111, in_data ch0..3 = 16'h1111/2222/3333/4444, out_ready=1 -> in_ready=4'b0100 each cycle; out_data=16'h3333 and out_ch=2 one cycle later, sustained every cycle.
- Fixed mode, absent request: mode=0, sel=1, in_valid=4'b1101 -> in_ready=0; out_valid drops to 0 after one cycle.
- Round-robin fairness: mode=1, all valid, out_ready=1 for 8 cycles -> out_ch sequence 0,1,2,3,0,1,2,3 with out_valid continuously 1.
- Sparse round-robin with wrap: mode=1, in_valid=4'b1010, ptr=0 -> grants 1, 3, 1, 3; the grant on ch3 wraps ptr to 0.
- Backpressure: out_ready=0 for 3 cycles while out_valid=1 -> out_data/out_ch stable and in_ready=0. On the cycle out_ready returns to 1, a new grant is accepted and the next word appears one cycle later with no bubble.
